regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 88 ++++++++
 tb/tb_regfile_scoreboard.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with a write-back bypass and an issue scoreboard; reads are combinational (0 cycles).
// Backpressure: stall holds back the offered instruction on RAW/WAW hazards, unless a same-cycle write-back resolves them.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int CW = $clog2(NREG + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    ra,
  input  logic [NREAD-1:0]       ra_used,
  output logic [NREAD*XLEN-1:0]  rdata,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [XLEN-1:0]        wd,
  input  logic                   iss_valid,
  input  logic                   iss_rd_en,
  input  logic [AW-1:0]          iss_rd,
  input  logic                   flush,
  output logic                   stall,
  output logic [NREG-1:0]        busy,
  output logic [CW-1:0]          pending_cnt
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREAD-1:0] hazard;
  logic             waw, fire, set_w, inc, dec, wr_en;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a_w;
    logic          byp_w;
    assign a_w   = ra[i*AW +: AW];
    assign byp_w = we & (wa == a_w);
    assign rdata[i*XLEN +: XLEN] = (rst || is_zero(a_w)) ? '0 :
                                   byp_w                  ? wd : mem_q[a_w];
    assign hazard[i] = ra_used[i] & busy_q[a_w] & ~byp_w;
  end

  assign waw   = iss_rd_en & busy_q[iss_rd] & ~(we & (wa == iss_rd));
  assign stall = ~rst & iss_valid & ((|hazard) | waw);
  assign fire  = iss_valid & ~stall & ~flush;
  assign set_w = fire & iss_rd_en & ~is_zero(iss_rd);
  assign wr_en = we & ~is_zero(wa);

  // A fired set never targets a busy register unless that register is being
  // retired this cycle, so the count moves by at most one in either direction.
  assign inc = set_w & ~busy_q[iss_rd];
  assign dec = we & busy_q[wa] & ~(set_w & (iss_rd == wa));

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      if (we)    busy_d[wa]     = 1'b0;
      if (set_w) busy_d[iss_rd] = 1'b1;
      cnt_d = cnt_q + {{(CW-1){1'b0}}, inc} - {{(CW-1){1'b0}}, dec};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      if (wr_en) mem_q[wa] <= wd;
    end
  end

  assign busy        = busy_q;
  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: integer (ZERO_REG=1) and FPU (ZERO_REG=0) instances share stimulus.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  ra;
  logic [1:0]  ra_used;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        iss_valid, iss_rd_en, flush;
  logic [4:0]  iss_rd;

  logic [63:0] rdata_z, rdata_n;
  logic        stall_z, stall_n;
  logic [31:0] busy_z, busy_n;
  logic [5:0]  cnt_z, cnt_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.ZERO_REG(1)) dz (
    .clk(clk), .rst(rst), .ra(ra), .ra_used(ra_used), .rdata(rdata_z),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd_en(iss_rd_en),
    .iss_rd(iss_rd), .flush(flush), .stall(stall_z), .busy(busy_z), .pending_cnt(cnt_z)
  );

  regfile_scoreboard #(.ZERO_REG(0)) dn (
    .clk(clk), .rst(rst), .ra(ra), .ra_used(ra_used), .rdata(rdata_n),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd_en(iss_rd_en),
    .iss_rd(iss_rd), .flush(flush), .stall(stall_n), .busy(busy_n), .pending_cnt(cnt_n)
  );

  // Model state: index 0 = zero-register file, index 1 = ordinary file.
  logic [31:0] m_mem  [2][32];
  bit          m_busy [2][32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input int c, input logic [4:0] a);
    if (rst) return 32'h0;
    if (c == 0 && a == 5'd0) return 32'h0;
    if (we && wa == a) return wd;
    return m_mem[c][a];
  endfunction

  function automatic bit m_stall(input int c);
    bit h;
    logic [4:0] a;
    h = 1'b0;
    if (rst || !iss_valid) return 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = ra[i*5 +: 5];
      if (ra_used[i] && m_busy[c][a] && !(we && wa == a)) h = 1'b1;
    end
    if (iss_rd_en && m_busy[c][iss_rd] && !(we && wa == iss_rd)) h = 1'b1;
    return h;
  endfunction

  function automatic logic [31:0] m_busy_vec(input int c);
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy[c][r];
    return v;
  endfunction

  function automatic logic [5:0] m_pop(input int c);
    int n;
    n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_busy[c][r]);
    return 6'(n);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++)
        for (int r = 0; r < 32; r++) begin
          m_mem[c][r]  <= 32'h0;
          m_busy[c][r] <= 1'b0;
        end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (we && !(c == 0 && wa == 5'd0)) m_mem[c][wa] <= wd;
        if (flush) begin
          for (int r = 0; r < 32; r++) m_busy[c][r] <= 1'b0;
        end else begin
          if (we) m_busy[c][wa] <= 1'b0;
          // A newly issued producer stays outstanding even if its register retires now.
          if (iss_valid && !m_stall(c) && iss_rd_en && !(c == 0 && iss_rd == 5'd0))
            m_busy[c][iss_rd] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("z.rdata0", rdata_z[31:0],  m_read(0, ra[4:0]));
    chk("z.rdata1", rdata_z[63:32], m_read(0, ra[9:5]));
    chk("z.stall",  stall_z,        m_stall(0));
    chk("z.busy",   busy_z,         m_busy_vec(0));
    chk("z.cnt",    cnt_z,          m_pop(0));
    chk("n.rdata0", rdata_n[31:0],  m_read(1, ra[4:0]));
    chk("n.rdata1", rdata_n[63:32], m_read(1, ra[9:5]));
    chk("n.stall",  stall_n,        m_stall(1));
    chk("n.busy",   busy_n,         m_busy_vec(1));
    chk("n.cnt",    cnt_n,          m_pop(1));
  end

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; iss_valid = 1'b0; iss_rd_en = 1'b0;
    iss_rd = '0; flush = 1'b0; ra_used = '0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1'b1; iss_rd_en = 1'b1; iss_rd = rd;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
  endtask

  initial begin
    idle();
    ra  = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    settle();
    chk("reset.busy", busy_z, 32'h0);
    chk("reset.cnt", cnt_z, 6'd0);
    chk("reset.stall", stall_z, 1'b0);
    adv();
    rst = 1'b0;

    // write then read next cycle
    wb(5'd5, 32'hDEADBEEF);
    adv(); idle();
    ra[4:0] = 5'd5;
    settle();
    chk("rd_after_wr", rdata_z[31:0], 32'hDEADBEEF);
    adv();

    // same-cycle bypass on port 1
    wb(5'd7, 32'h12);
    ra[9:5] = 5'd7;
    settle();
    chk("bypass", rdata_z[63:32], 32'h12);
    adv(); idle();

    // RAW stall, resolved by same-cycle write-back
    issue(5'd3);
    adv(); idle();
    ra[4:0] = 5'd3; ra_used = 2'b01; iss_valid = 1'b1;
    settle();
    chk("raw.stall", stall_z, 1'b1);
    chk("raw.cnt", cnt_z, 6'd1);
    adv();
    wb(5'd3, 32'h33);
    settle();
    chk("raw.resolve", stall_z, 1'b0);
    adv(); idle();
    settle();
    chk("raw.busy3", busy_z[3], 1'b0);
    chk("raw.cnt0", cnt_z, 6'd0);
    adv();

    // register 0 behaviour in both files
    issue(5'd0); wb(5'd0, 32'hFF); ra[4:0] = 5'd0;
    adv(); idle();
    settle();
    chk("zr.busy", busy_z, 32'h0);
    chk("zr.read", rdata_z[31:0], 32'h0);
    chk("nz.busy0", busy_n[0], 1'b1);
    chk("nz.read", rdata_n[31:0], 32'hFF);
    adv();
    wb(5'd0, 32'hFF);
    adv(); idle();

    // flush overrides a simultaneous issue
    issue(5'd1); adv();
    issue(5'd2); adv();
    issue(5'd4); adv(); idle();
    settle();
    chk("fl.cnt3", cnt_z, 6'd3);
    adv();
    issue(5'd6); flush = 1'b1;
    adv(); idle();
    settle();
    chk("fl.busy", busy_z, 32'h0);
    chk("fl.cnt", cnt_z, 6'd0);
    adv();

    // WAW stall, then a write-back to a non-busy register
    issue(5'd11); adv();
    issue(5'd11);
    settle();
    chk("waw.stall", stall_z, 1'b1);
    adv(); idle();
    wb(5'd20, 32'h77);
    adv(); idle();
    ra[4:0] = 5'd20;
    settle();
    chk("nb.busy", busy_z, 32'h0000_0800);
    chk("nb.read", rdata_z[31:0], 32'h77);
    adv();
    wb(5'd11, 32'hB);
    adv(); idle();

    // unused source does not stall; used source on port 1 does
    issue(5'd13); adv(); idle();
    ra[9:5] = 5'd13; iss_valid = 1'b1;
    settle();
    chk("unused.stall", stall_z, 1'b0);
    adv();
    ra_used = 2'b10;
    settle();
    chk("used1.stall", stall_z, 1'b1);
    adv(); idle();
    wb(5'd13, 32'hD);
    adv(); idle();

    // retire and re-issue the same register in one cycle
    issue(5'd9); adv();
    issue(5'd10); adv(); idle();
    issue(5'd9); wb(5'd9, 32'h99);
    settle();
    chk("same.stall", stall_z, 1'b0);
    adv(); idle();
    settle();
    chk("same.busy9", busy_z[9], 1'b1);
    chk("same.cnt", cnt_z, 6'd2);

    // asynchronous reset mid-sequence; writes under reset are dropped
    wb(5'd12, 32'h55); issue(5'd14); ra = {5'd9, 5'd12}; ra_used = 2'b11;
    #1 rst = 1'b1;
    #1;
    chk("arst.busy", busy_z, 32'h0);
    chk("arst.cnt", cnt_z, 6'd0);
    chk("arst.stall", stall_z, 1'b0);
    chk("arst.rdata", rdata_z, 64'h0);
    adv();
    rst = 1'b0;
    idle();
    ra = {5'd5, 5'd12};
    settle();
    chk("post.rd12", rdata_z[31:0], 32'h0);
    chk("post.rd5", rdata_z[63:32], 32'h0);
    chk("post.busy", busy_n, 32'h0);
    adv();
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
